// File: rtl/cv32e40px_apu_arbiter_pkg.sv
// Shared APU widths and request payload type for the APU arbiter.
// Imported by the arbiter top and its ID FIFO.
package cv32e40px_apu_arbiter_pkg;

    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_req_t;

endpackage

// File: rtl/cv32e40px_apu_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding APU operations.
// Ports: push_i/data_i write, pop_i/data_o read, full_o/empty_o/count_o status.
module cv32e40px_apu_id_fifo
    import cv32e40px_apu_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            // DEPTH is a power of two, so pointers wrap naturally
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cv32e40px_apu_arbiter.sv
// Round-robin arbiter sharing one APU among NUM_CORES cores; routes
// results back in issue order. Ports: core_* per-core side, apu_* APU side,
// outstanding_o in-flight count, err_o sticky unexpected-result flag.
module cv32e40px_apu_arbiter
    import cv32e40px_apu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = $clog2(NUM_CORES)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_CORES-1:0]                       core_req_i,
    output logic [NUM_CORES-1:0]                       core_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0] core_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]      core_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0] core_flags_i,
    output logic [NUM_CORES-1:0]                       core_rvalid_o,
    output logic [31:0]                                core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                core_rflags_o,
    output logic                                       apu_req_o,
    input  logic                                       apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]             apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                     apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                apu_flags_o,
    input  logic                                       apu_rvalid_i,
    input  logic [31:0]                                apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                apu_rflags_i,
    output logic [$clog2(FIFO_DEPTH):0]                outstanding_o,
    output logic                                       err_o
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [ID_W-1:0] locked_id_q, locked_id_d;
    logic            err_q, err_d;

    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] head_id;
    logic            any_req, accept, pop;
    logic            fifo_full, fifo_empty;
    apu_req_t        sel_pl;

    // First requester found scanning upward from ptr, wrapping around
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_CORES-1:0] req,
        input logic [ID_W-1:0]      ptr
    );
        logic [ID_W-1:0] id;
        logic            found;
        int unsigned     k;
        id    = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            k = (int'(ptr) + i) % NUM_CORES;
            if (!found && req[k]) begin
                found = 1'b1;
                id    = ID_W'(k);
            end
        end
        return id;
    endfunction

    assign any_req = |core_req_i;
    assign winner  = lock_q ? locked_id_q : rr_pick(core_req_i, rr_ptr_q);

    assign apu_req_o = core_req_i[winner] & any_req & ~fifo_full;
    assign accept    = apu_req_o & apu_gnt_i;
    assign pop       = apu_rvalid_i & ~fifo_empty;

    always_comb begin
        sel_pl = '0;
        if (any_req) begin
            sel_pl.operands = core_operands_i[winner];
            sel_pl.op       = core_op_i[winner];
            sel_pl.flags    = core_flags_i[winner];
        end
    end

    assign apu_operands_o = sel_pl.operands;
    assign apu_op_o       = sel_pl.op;
    assign apu_flags_o    = sel_pl.flags;

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (accept) core_gnt_o[winner] = 1'b1;
        if (pop)    core_rvalid_o[head_id] = 1'b1;
    end

    assign core_result_o = apu_result_i;
    assign core_rflags_o = apu_rflags_i;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        err_d       = err_q | (apu_rvalid_i & fifo_empty);
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = (winner == ID_W'(NUM_CORES-1)) ? '0
                                                      : winner + ID_W'(1);
        end else if (apu_req_o) begin
            // Stalled by the APU: hold this core until it is accepted
            lock_d      = 1'b1;
            locked_id_d = winner;
        end else if (lock_q && !core_req_i[locked_id_q]) begin
            // Locked core withdrew its request; release the lock
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
        end
    end

    assign err_o = err_q;

    cv32e40px_apu_id_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule
